// File: rtl/decoder_scan_seq.sv
// rtl/decoder_scan_seq.sv - auto-scan / manual-step sequencer driving a 3-to-8 decoder select
module decoder_scan_seq #(
    parameter int DWELL  = 4,
    parameter int FRAMES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic stop,
    input  logic step_mode,
    input  logic step,
    output logic en,
    output logic in2,
    output logic in1,
    output logic in0,
    output logic busy,
    output logic wrap,
    output logic done
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        STEP
    } state_t;

    localparam logic [7:0] DWELL_LAST  = 8'(DWELL - 1);
    localparam logic [7:0] FRAME_LIMIT = 8'(FRAMES);

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] dwell_q, dwell_d;
    logic [7:0] frame_q, frame_d;
    logic [7:0] frame_inc;
    logic       advance;
    logic       wrap_d;
    logic       done_d;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        dwell_d   = dwell_q;
        frame_d   = frame_q;
        frame_inc = frame_q + 8'd1;
        advance   = 1'b0;
        wrap_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = step_mode ? STEP : SCAN;
                    sel_d   = 3'd0;
                    dwell_d = 8'd0;
                    frame_d = 8'd0;
                end
            end
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = 8'd0;
                    advance = 1'b1;
                end else begin
                    dwell_d = dwell_q + 8'd1;
                end
            end
            STEP:    advance = step;
            default: state_d = IDLE;
        endcase

        // The wrap that completes the last frame returns to IDLE in the same cycle
        if (state_q != IDLE && advance) begin
            sel_d = sel_q + 3'd1;
            if (sel_q == 3'd7) begin
                wrap_d  = 1'b1;
                frame_d = frame_inc;
                if (FRAMES != 0 && frame_inc == FRAME_LIMIT) begin
                    state_d = IDLE;
                    sel_d   = 3'd0;
                    done_d  = 1'b1;
                end
            end
        end

        // stop overrides every other event, and suppresses wrap/done
        if (state_q != IDLE && stop) begin
            state_d = IDLE;
            sel_d   = 3'd0;
            dwell_d = 8'd0;
            frame_d = 8'd0;
            wrap_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            sel_q           <= 3'd0;
            dwell_q         <= 8'd0;
            frame_q         <= 8'd0;
            en              <= 1'b0;
            busy            <= 1'b0;
            {in2, in1, in0} <= 3'd0;
            wrap            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state_q         <= state_d;
            sel_q           <= sel_d;
            dwell_q         <= dwell_d;
            frame_q         <= frame_d;
            en              <= (state_d != IDLE);
            busy            <= (state_d != IDLE);
            {in2, in1, in0} <= sel_d;
            wrap            <= wrap_d;
            done            <= done_d;
        end
    end

endmodule

// File: tb/tb_decoder_scan_seq.sv
// tb/tb_decoder_scan_seq.sv - scoreboard bench for decoder_scan_seq (two parameter sets)
module tb_decoder_scan_seq;

    logic clk = 1'b0;
    logic rst_n, start, stop, step_mode, step;
    logic en_a, in2_a, in1_a, in0_a, busy_a, wrap_a, done_a;
    logic en_b, in2_b, in1_b, in0_b, busy_b, wrap_b, done_b;

    always #5 clk = ~clk;

    decoder_scan_seq #(.DWELL(4), .FRAMES(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .step_mode(step_mode), .step(step),
        .en(en_a), .in2(in2_a), .in1(in1_a), .in0(in0_a),
        .busy(busy_a), .wrap(wrap_a), .done(done_a)
    );

    decoder_scan_seq #(.DWELL(2), .FRAMES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .step_mode(step_mode), .step(step),
        .en(en_b), .in2(in2_b), .in1(in1_b), .in0(in0_b),
        .busy(busy_b), .wrap(wrap_b), .done(done_b)
    );

    // Packed as {en, in2, in1, in0, busy, wrap, done}
    typedef struct packed {
        logic [6:0] a;
        logic [6:0] b;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_total = 0;
    int    n_pass  = 0;

    localparam logic [6:0] IDLE_V = 7'b0000000;
    localparam logic [6:0] DONE_V = 7'b0000011;

    function automatic logic [6:0] act(input int s, input bit w);
        logic [2:0] s3;
        s3 = 3'(s);
        return {1'b1, s3, 1'b1, w, 1'b0};
    endfunction

    task automatic cycle(input string tag, input logic [6:0] ea, input logic [6:0] eb);
        exp_t  e;
        string t;
        logic [6:0] obs_a, obs_b;
        exp_q.push_back('{a: ea, b: eb});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e     = exp_q.pop_front();
        t     = tag_q.pop_front();
        obs_a = {en_a, in2_a, in1_a, in0_a, busy_a, wrap_a, done_a};
        obs_b = {en_b, in2_b, in1_b, in0_b, busy_b, wrap_b, done_b};
        n_total++;
        assert (obs_a === e.a) n_pass++;
        else $error("FAIL %s dut_a observed=%b expected=%b", t, obs_a, e.a);
        n_total++;
        assert (obs_b === e.b) n_pass++;
        else $error("FAIL %s dut_b observed=%b expected=%b", t, obs_b, e.b);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; step_mode = 1'b0; step = 1'b0;
        cycle("reset0", IDLE_V, IDLE_V);
        cycle("reset1", IDLE_V, IDLE_V);

        rst_n = 1'b1;
        cycle("idle_after_reset", IDLE_V, IDLE_V);

        // Auto-scan: a holds each select 4 cycles forever, b runs two frames at dwell 2
        start = 1'b1;
        cycle("scan_start", act(0, 0), act(0, 0));
        for (int k = 1; k <= 70; k++) begin
            logic [6:0] eb;
            start     = (k == 10);
            step      = (k == 12);
            step_mode = (k == 14);
            if (k < 32)       eb = act((k / 2) % 8, (k % 16) == 0);
            else if (k == 32) eb = DONE_V;
            else              eb = IDLE_V;
            cycle($sformatf("scan_k%0d", k), act((k / 4) % 8, (k % 32) == 0), eb);
        end
        step_mode = 1'b0;

        start = 1'b1; stop = 1'b1;
        cycle("stop_with_start", IDLE_V, IDLE_V);
        start = 1'b0; stop = 1'b0;
        cycle("idle_after_stop", IDLE_V, IDLE_V);

        start = 1'b1;
        cycle("restart", act(0, 0), act(0, 0));
        start = 1'b0;
        for (int k = 1; k <= 21; k++)
            cycle($sformatf("rescan_k%0d", k), act((k / 4) % 8, 1'b0),
                  act((k / 2) % 8, (k % 16) == 0));

        // dut_a is at select 5 here
        rst_n = 1'b0; start = 1'b1;
        cycle("reset_midscan", IDLE_V, IDLE_V);
        cycle("reset_held_start", IDLE_V, IDLE_V);
        rst_n = 1'b1; start = 1'b0;
        cycle("idle_post_reset", IDLE_V, IDLE_V);

        // Manual step mode
        start = 1'b1; step_mode = 1'b1;
        cycle("step_start", act(0, 0), act(0, 0));
        start = 1'b0; step_mode = 1'b0;
        cycle("step_hold0", act(0, 0), act(0, 0));
        for (int i = 1; i <= 9; i++) begin
            step = 1'b1;
            cycle($sformatf("step_pulse%0d", i), act(i % 8, i == 8), act(i % 8, i == 8));
            step = 1'b0;
            cycle($sformatf("step_gap%0d", i), act(i % 8, 1'b0), act(i % 8, 1'b0));
        end
        step = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            logic [6:0] eb;
            if (j < 7)       eb = act(1 + j, 1'b0);
            else if (j == 7) eb = DONE_V;
            else             eb = IDLE_V;
            cycle($sformatf("step_held%0d", j), act((1 + j) % 8, j == 7), eb);
        end
        step = 1'b0; stop = 1'b1;
        cycle("step_stop", IDLE_V, IDLE_V);
        stop = 1'b0;
        cycle("final_idle", IDLE_V, IDLE_V);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
